// File: rtl/prot_key_seq_if.sv
// prot_key_seq_if: bus-snoop port bundle shared by the bus master and the key sequencer
//   sser_n  - select, active low          (master -> slave)
//   ba      - 14-bit bus address          (master -> slave)
//   br_w    - 1=read, 0=write             (master -> slave)
//   acc_stb - one-cycle access strobe     (master -> slave)
//   sdrd    - serial response bit         (slave -> master)
//   sdrd_oe - drive enable for sdrd       (slave -> master)
interface prot_key_seq_if;
    logic        sser_n;
    logic [13:0] ba;
    logic        br_w;
    logic        acc_stb;
    logic        sdrd;
    logic        sdrd_oe;
    modport master (output sser_n, ba, br_w, acc_stb, input sdrd, sdrd_oe);
    modport slave  (input sser_n, ba, br_w, acc_stb, output sdrd, sdrd_oe);
endinterface

// File: rtl/prot_key_seq.sv
// prot_key_seq: bus-snooping protection-key sequencer with NUM_CH LFSR response channels
//   clk      - system clock
//   rst_n    - synchronous active-low reset
//   bus      - prot_key_seq_if.slave (sser_n, ba, br_w, acc_stb in; sdrd, sdrd_oe out)
//   unlocked - registered, high while in RUN
//   lfsr_dbg - LFSR state of the channel selected by ba[9:8]
//   Optional macro PROT_KEY_TIMEOUT_EN: auto-relock after TIMEOUT idle clocks in RUN.
module prot_key_seq #(
    parameter int                 STATE_W  = 6,
    parameter logic [STATE_W-1:0] TAP_MASK = 'h30,
    parameter logic [STATE_W-1:0] SEED     = 'h01,
    parameter int                 KEY_LEN  = 4,
    parameter logic [15:0]        KEY_SEQ  = 16'h2A58,
    parameter int                 NUM_CH   = 2,
    parameter int                 TIMEOUT  = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    prot_key_seq_if.slave      bus,
    output logic               unlocked,
    output logic [STATE_W-1:0] lfsr_dbg
);
    localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;
    state_t             state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic               unlocked_q, unlocked_d;
    logic [STATE_W-1:0] lfsr_q [NUM_CH];
    logic [STATE_W-1:0] lfsr_d [NUM_CH];
    logic               in_win, hit, rd_hit, wr_hit, reload_all;
    logic [CH_W-1:0]    ch;
    logic [3:0]         nib, exp_nib;
`ifdef PROT_KEY_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    // SEED ^ ch can be zero (e.g. SEED=1, ch=1); fall back to SEED so no channel ever locks up
    function automatic logic [STATE_W-1:0] reload(input int c);
        logic [STATE_W-1:0] v;
        v = SEED ^ STATE_W'(c);
        return v == '0 ? SEED : v;
    endfunction

    function automatic logic [STATE_W-1:0] lfsr_step(input logic [STATE_W-1:0] v, input int c);
        logic [STATE_W-1:0] n;
        n = {v[STATE_W-2:0], ^(v & TAP_MASK)};
        return n == '0 ? reload(c) : n;
    endfunction

    assign in_win = ~bus.sser_n && bus.ba[13:12] == 2'b01;
    assign hit    = in_win && bus.acc_stb;
    assign rd_hit = hit && bus.br_w;
    assign wr_hit = hit && !bus.br_w;
    assign ch     = CH_W'(32'(bus.ba[9:8]) % NUM_CH);
    assign nib    = bus.ba[7:4];
    // key nibbles live in the low KEY_LEN*4 bits, most-significant nibble consumed first
    assign exp_nib = 4'((KEY_SEQ << {idx_q, 2'b00}) >> (4 * KEY_LEN - 4));

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        lfsr_d     = lfsr_q;
        reload_all = 1'b0;
`ifdef PROT_KEY_TIMEOUT_EN
        cnt_d = '0;
        if (state_q == RUN && !hit) begin
            if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                state_d    = IDLE;
                reload_all = 1'b1;
            end else
                cnt_d = cnt_q + 1'b1;
        end
`endif
        if (wr_hit && nib == 4'hF) begin
            state_d    = IDLE;
            idx_d      = '0;
            reload_all = 1'b1;
        end else if (rd_hit) begin
            case (state_q)
                // idx is 0 in IDLE, so IDLE and ARM share the nibble match
                IDLE, ARM: begin
                    if (nib != exp_nib) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end else if (idx_q == 2'(KEY_LEN - 1)) begin
                        state_d    = RUN;
                        idx_d      = '0;
                        reload_all = 1'b1;
                    end else begin
                        state_d = ARM;
                        idx_d   = idx_q + 1'b1;
                    end
                end
                RUN:     lfsr_d[ch] = lfsr_step(lfsr_q[ch], int'(ch));
                default: state_d = IDLE;
            endcase
        end
        if (reload_all)
            for (int i = 0; i < NUM_CH; i++) lfsr_d[i] = reload(i);
        unlocked_d = state_d == RUN;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            unlocked_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) lfsr_q[i] <= reload(i);
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            unlocked_q <= unlocked_d;
            lfsr_q     <= lfsr_d;
        end
    end

`ifdef PROT_KEY_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`endif

    assign bus.sdrd_oe = in_win && bus.br_w;
    assign bus.sdrd    = state_q == RUN ? lfsr_q[ch][STATE_W-1] : 1'b1;
    assign unlocked    = unlocked_q;
    assign lfsr_dbg    = lfsr_q[ch];
endmodule

// File: tb/tb_prot_key_seq.sv
// tb_prot_key_seq: randomized + directed bench for prot_key_seq against a key-progress model
module tb_prot_key_seq;
    localparam int          STATE_W  = 6;
    localparam int          TAP_MASK = 'h30;
    localparam int          SEED     = 'h01;
    localparam int          KEY_LEN  = 4;
    localparam int          KEY_SEQ  = 'h2A58;
    localparam int          NUM_CH   = 2;
    localparam int          TIMEOUT  = 255;
    localparam int          MASK     = (1 << STATE_W) - 1;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               unlocked;
    logic [STATE_W-1:0] lfsr_dbg;
    int                 n_cmp = 0;
    int                 n_err = 0;
    bit                 chk_en = 1'b0;
    int                 m_prog;
    int                 m_idle;
    int                 m_lfsr [4];

    prot_key_seq_if bus ();

    prot_key_seq #(
        .STATE_W(STATE_W), .TAP_MASK(STATE_W'(TAP_MASK)), .SEED(STATE_W'(SEED)),
        .KEY_LEN(KEY_LEN), .KEY_SEQ(16'(KEY_SEQ)), .NUM_CH(NUM_CH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave), .unlocked(unlocked), .lfsr_dbg(lfsr_dbg)
    );

    always #5 clk = ~clk;

    function automatic int key(input int k);
        return (KEY_SEQ >> (4 * (KEY_LEN - 1 - k))) & 15;
    endfunction

    function automatic int rel(input int c);
        int v;
        v = (SEED ^ c) & MASK;
        return v == 0 ? SEED : v;
    endfunction

    function automatic int stepm(input int v, input int c);
        int n;
        n = ((v * 2) + ($countones(v & TAP_MASK) % 2)) & MASK;
        return n == 0 ? rel(c) : n;
    endfunction

    function automatic void reload_m();
        for (int c = 0; c < NUM_CH; c++) m_lfsr[c] = rel(c);
    endfunction

    task automatic lit(input string nm, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // model: key progress 0..KEY_LEN (KEY_LEN = unlocked) plus per-channel LFSR values
    always @(posedge clk) begin
        int  c, nb;
        bit  hit, rd;
        c   = int'(bus.ba[9:8]) % NUM_CH;
        nb  = int'(bus.ba[7:4]);
        hit = !bus.sser_n && bus.ba[13:12] == 2'b01 && bus.acc_stb;
        rd  = bus.br_w;
        if (!rst_n) begin
            m_prog = 0;
            m_idle = 0;
            reload_m();
        end else begin
`ifdef PROT_KEY_TIMEOUT_EN
            if (m_prog == KEY_LEN && !hit) begin
                m_idle++;
                if (m_idle == TIMEOUT) begin
                    m_prog = 0;
                    m_idle = 0;
                    reload_m();
                end
            end else
                m_idle = 0;
`endif
            if (hit && !rd && nb == 15) begin
                m_prog = 0;
                reload_m();
            end else if (hit && rd) begin
                if (m_prog == KEY_LEN)
                    m_lfsr[c] = stepm(m_lfsr[c], c);
                else if (nb == key(m_prog)) begin
                    m_prog++;
                    if (m_prog == KEY_LEN) reload_m();
                end else
                    m_prog = 0;
            end
        end
    end

    always @(negedge clk) begin
        int c;
        bit run;
        if (chk_en) begin
            c   = int'(bus.ba[9:8]) % NUM_CH;
            run = m_prog == KEY_LEN;
            lit("sdrd_oe", 16'(bus.sdrd_oe), 16'(!bus.sser_n && bus.ba[13:12] == 2'b01 && bus.br_w));
            lit("sdrd", 16'(bus.sdrd), 16'(run ? (m_lfsr[c] >> (STATE_W - 1)) & 1 : 1));
            lit("unlocked", 16'(unlocked), 16'(run));
            lit("lfsr_dbg", 16'(lfsr_dbg), 16'(m_lfsr[c]));
            lit("lfsr_nonzero", 16'(lfsr_dbg != 0), 16'd1);
        end
    end

    task automatic drive(input logic [13:0] a, input logic rd, input logic stb, input logic sel_n);
        @(posedge clk);
        #1;
        bus.sser_n  = sel_n;
        bus.ba      = a;
        bus.br_w    = rd;
        bus.acc_stb = stb;
    endtask

    task automatic acc(input logic [13:0] a, input logic rd);
        drive(a, rd, 1'b1, 1'b0);
    endtask

    task automatic idle(input logic [13:0] a);
        drive(a, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic unlock();
        acc(14'h1020, 1'b1);
        acc(14'h10A0, 1'b1);
        acc(14'h1050, 1'b1);
        acc(14'h1080, 1'b1);
    endtask

    initial begin
        int exp_sd [6] = '{0, 0, 0, 0, 0, 1};
        int exp_lf [6] = '{'h01, 'h02, 'h04, 'h08, 'h10, 'h21};
        logic [13:0] a;
        logic [3:0]  nb;
        bus.sser_n  = 1'b1;
        bus.ba      = '0;
        bus.br_w    = 1'b0;
        bus.acc_stb = 1'b0;
        rst_n       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;
        // reset state seen through a window read
        acc(14'h1020, 1'b1);
        @(negedge clk);
        lit("rst_sdrd_oe", 16'(bus.sdrd_oe), 16'd1);
        lit("rst_sdrd", 16'(bus.sdrd), 16'd1);
        lit("rst_unlocked", 16'(unlocked), 16'd0);
        lit("rst_lfsr", 16'(lfsr_dbg), 16'h01);
        acc(14'h10F0, 1'b1);
        idle(14'h1000);
        @(negedge clk);
        lit("idle_f_read", 16'(unlocked), 16'd0);
        // unlock and walk channel 0
        unlock();
        for (int i = 0; i < 6; i++) begin
            acc(14'h1000, 1'b1);
            @(negedge clk);
            if (i == 0) lit("unlocked_after_key", 16'(unlocked), 16'd1);
            lit("ch0_sdrd", 16'(bus.sdrd), 16'(exp_sd[i]));
            lit("ch0_lfsr", 16'(lfsr_dbg), 16'(exp_lf[i]));
        end
        // channel 1 reloads to SEED because SEED^1 is zero
        for (int i = 0; i < 3; i++) begin
            acc(14'h1100, 1'b1);
            @(negedge clk);
            lit("ch1_lfsr", 16'(lfsr_dbg), 16'(1 << i));
        end
        idle(14'h1100);
        @(negedge clk);
        lit("ch1_after3", 16'(lfsr_dbg), 16'h08);
        idle(14'h1000);
        @(negedge clk);
        lit("ch0_held", 16'(lfsr_dbg), 16'h03);
        // writes: only nibble F relocks
        acc(14'h1020, 1'b0);
        idle(14'h1000);
        @(negedge clk);
        lit("wr_ignored", 16'(unlocked), 16'd1);
        acc(14'h10F0, 1'b0);
        idle(14'h1000);
        @(negedge clk);
        lit("relock_unlocked", 16'(unlocked), 16'd0);
        lit("relock_sdrd", 16'(bus.sdrd), 16'd1);
        lit("relock_lfsr", 16'(lfsr_dbg), 16'h01);
        // 2,A,7 aborts; 5,8 alone must not unlock
        acc(14'h1020, 1'b1);
        acc(14'h10A0, 1'b1);
        acc(14'h1070, 1'b1);
        acc(14'h1050, 1'b1);
        acc(14'h1080, 1'b1);
        idle(14'h1000);
        @(negedge clk);
        lit("abort_27", 16'(unlocked), 16'd0);
        // mismatching 2 in ARM is not re-tested as the first nibble
        acc(14'h1020, 1'b1);
        acc(14'h1020, 1'b1);
        acc(14'h10A0, 1'b1);
        acc(14'h1050, 1'b1);
        acc(14'h1080, 1'b1);
        idle(14'h1000);
        @(negedge clk);
        lit("no_retest", 16'(unlocked), 16'd0);
        unlock();
        idle(14'h1000);
        @(negedge clk);
        lit("reunlock", 16'(unlocked), 16'd1);
        // reset beats a simultaneous hit
        acc(14'h1000, 1'b1);
        rst_n = 1'b0;
        idle(14'h1000);
        rst_n = 1'b1;
        @(negedge clk);
        lit("rst_vs_hit_unl", 16'(unlocked), 16'd0);
        lit("rst_vs_hit_lfsr", 16'(lfsr_dbg), 16'h01);
`ifdef PROT_KEY_TIMEOUT_EN
        unlock();
        repeat (255) idle(14'h1000);
        @(negedge clk);
        lit("to_254", 16'(unlocked), 16'd1);
        idle(14'h1000);
        @(negedge clk);
        lit("to_255", 16'(unlocked), 16'd0);
        unlock();
        repeat (200) idle(14'h1000);
        acc(14'h1000, 1'b1);
        repeat (255) idle(14'h1000);
        @(negedge clk);
        lit("to_restart", 16'(unlocked), 16'd1);
        idle(14'h1000);
        @(negedge clk);
        lit("to_restart_expire", 16'(unlocked), 16'd0);
`endif
        // randomized traffic biased toward the key so RUN is visited often
        for (int i = 0; i < 4000; i++) begin
            nb = (m_prog < KEY_LEN && $urandom_range(0, 3) != 0) ? 4'(key(m_prog)) : 4'($urandom);
            a  = {($urandom_range(0, 9) != 0) ? 2'b01 : 2'($urandom), 4'($urandom), nb, 4'($urandom)};
            drive(a, $urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
            rst_n = $urandom_range(0, 299) != 0;
        end
        idle(14'h1000);
        rst_n = 1'b1;
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
